// File: rtl/otter_fetch_queue.sv
// OTTER RV32I fetch front end: owns the fetch PC, issues credit-limited imem requests and
// queues returned words with their PCs for decode. Optional perf counters: OTTER_FETCH_PERF_CNT_EN.
module otter_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_ir,
    output logic [31:0] o_if_pc,
    input  logic        i_de_ready,
    output logic [31:0] o_perf_redirects,
    output logic [31:0] o_perf_starve
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_q_ir [QUEUE_DEPTH];
    logic [31:0]   r_q_pc [QUEUE_DEPTH];

    logic [31:0] w_redirect_pc;
    logic [31:0] w_inflight;
    logic        w_grant;
    logic        w_rsp;
    logic        w_push;
    logic        w_pop;
    logic        w_unused;

    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
    assign w_unused      = ^i_redirect_pc[1:0];

    // Queue slots are reserved at request time, so a returning word always has room.
    assign w_inflight = 32'(r_count) + 32'(r_outstanding);
    assign o_imem_req = !i_reset && !i_redirect
                        && (w_inflight < 32'(QUEUE_DEPTH))
                        && (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
    assign o_imem_addr = r_fetch_pc;

    assign w_grant = o_imem_req && i_imem_gnt;
    assign w_rsp   = i_imem_rvalid && (r_outstanding != '0);
    assign w_push  = w_rsp && (r_drop_cnt == '0) && !i_redirect;

    assign o_if_valid = (r_count != '0);
    assign w_pop      = o_if_valid && i_de_ready && !i_redirect;
    assign o_if_ir    = o_if_valid ? r_q_ir[r_rptr] : '0;
    assign o_if_pc    = o_if_valid ? r_q_pc[r_rptr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_outstanding <= r_outstanding + OW'(w_grant) - OW'(w_rsp);
            if (i_redirect) begin
                // Everything still in flight belongs to the old path and must be skipped.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= r_outstanding - OW'(w_rsp);
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - OW'(1);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_wptr   <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_ir[r_wptr] <= i_imem_rdata;
            r_q_pc[r_wptr] <= r_rsp_pc;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(i_imem_rvalid && (r_outstanding == '0)));
        end
    end
`endif

`ifdef OTTER_FETCH_PERF_CNT_EN
    logic [31:0] r_perf_redirects;
    logic [31:0] r_perf_starve;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_redirects <= '0;
            r_perf_starve    <= '0;
        end else begin
            if (i_redirect && (r_perf_redirects != '1)) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
            if (!o_if_valid && !i_redirect && (r_perf_starve != '1)) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
        end
    end

    assign o_perf_redirects = r_perf_redirects;
    assign o_perf_starve    = r_perf_starve;
`else
    assign o_perf_redirects = '0;
    assign o_perf_starve    = '0;
`endif

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Scoreboard bench for otter_fetch_queue: a variable-latency imem responder, expected-PC queue
// filled by the stimulus, and a decode-side monitor that pops and compares.
module tb_otter_fetch_queue;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_ir;
    logic [31:0] o_if_pc;
    logic        i_de_ready;
    logic [31:0] o_perf_redirects;
    logic [31:0] o_perf_starve;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          neg_cyc = 0;
    int          grants  = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    always #5 clk = ~clk;

    otter_fetch_queue dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_gnt       (i_imem_gnt),
        .i_imem_rvalid    (i_imem_rvalid),
        .i_imem_rdata     (i_imem_rdata),
        .o_if_valid       (o_if_valid),
        .o_if_ir          (o_if_ir),
        .o_if_pc          (o_if_pc),
        .i_de_ready       (i_de_ready),
        .o_perf_redirects (o_perf_redirects),
        .o_perf_starve    (o_perf_starve)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // imem model: in-order responses, latency drawn per grant from [lat_min, lat_max]
    initial begin : responder
        int          pre;
        logic        waiting;
        logic [31:0] wait_addr;
        waiting       = 1'b0;
        wait_addr     = '0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        forever begin
            @(negedge clk);
            neg_cyc++;
            i_imem_rvalid = 1'b0;
            if (i_reset) begin
                pend_addr.delete();
                pend_due.delete();
                waiting = 1'b0;
            end else begin
                pre = pend_addr.size();
                if (pre > 0 && pend_due[0] <= neg_cyc + 1) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = mem_word(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (waiting && o_imem_req) check("addr_hold", o_imem_addr, wait_addr);
                if (o_imem_req && i_imem_gnt) begin
                    grants++;
                    check("outstanding_limit", 32'(pre < MAXO), 32'd1);
                    pend_addr.push_back(o_imem_addr);
                    pend_due.push_back(neg_cyc + 1 + int'($urandom_range(lat_max, lat_min)));
                end
                waiting   = o_imem_req && !i_imem_gnt;
                wait_addr = o_imem_addr;
            end
        end
    end

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!i_reset && o_if_valid && i_de_ready && !i_redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual_pc=0x%08h required=no_entry", o_if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", o_if_pc, e);
                    check("if_ir", o_if_ir, mem_word(e));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        i_reset       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_imem_gnt    = 1'b0;
        i_de_ready    = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_if_valid", 32'(o_if_valid), 32'd0);
        check("rst_if_pc", o_if_pc, 32'd0);
        check("rst_if_ir", o_if_ir, 32'd0);
        check("rst_imem_req", 32'(o_imem_req), 32'd0);
        check("rst_imem_addr", o_imem_addr, 32'd0);
        check("rst_perf_redirects", o_perf_redirects, 32'd0);
        check("rst_perf_starve", o_perf_starve, 32'd0);
        @(posedge clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc, input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
            if (rnd) begin
                i_imem_gnt = 1'($urandom_range(1, 0));
                i_de_ready = (exp_q.size() != 0) && ($urandom_range(1, 0) == 1);
            end
        end
        i_de_ready = 1'b0;
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stimulus
        int          n;
        int          g0;
        logic [31:0] pc;
        i_reset       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_imem_gnt    = 1'b0;
        i_de_ready    = 1'b0;

        // perf: 3 redirect cycles then 10 starved cycles, no grants
        do_reset();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0040;
        repeat (3) begin @(posedge clk); #1; end
        i_redirect = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
`ifdef OTTER_FETCH_PERF_CNT_EN
        check("perf_redirects", o_perf_redirects, 32'd3);
        check("perf_starve", o_perf_starve, 32'd10);
`else
        check("perf_redirects", o_perf_redirects, 32'd0);
        check("perf_starve", o_perf_starve, 32'd0);
`endif

        // streaming: gnt=1, latency 1, decode always ready
        do_reset();
        lat_min = 1; lat_max = 1;
        i_imem_gnt = 1'b1;
        i_de_ready = 1'b1;
        push_stream(32'h0, 16);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) check("t1_first_addr", o_imem_addr, 32'h0);
            check("t1_req_steady", 32'(o_imem_req), 32'd1);
            check("t1_if_valid", 32'(o_if_valid), (k < 2) ? 32'd0 : 32'd1);
        end
        wait_drain("t1", 100, 1'b0);

        // decode stalled: exactly QUEUE_DEPTH grants, then drain resumes at 0x10
        do_reset();
        g0 = grants;
        lat_min = 1; lat_max = 1;
        i_imem_gnt = 1'b1;
        push_stream(32'h0, 6);
        repeat (12) begin @(posedge clk); #1; end
        check("t2_grants", 32'(grants - g0), 32'd4);
        @(negedge clk);
        check("t2_req_stalled", 32'(o_imem_req), 32'd0);
        check("t2_head_pc", o_if_pc, 32'h0);
        @(posedge clk); #1;
        i_de_ready = 1'b1;
        wait_drain("t2", 100, 1'b0);

        // redirect with 0x8/0xC in flight; target low bits ignored
        do_reset();
        lat_min = 4; lat_max = 4;
        i_imem_gnt = 1'b1;
        i_de_ready = 1'b1;
        push_stream(32'h0, 2);
        n = 0;
        while (!(pend_addr.size() == 2 ? (pend_addr[0] == 32'h8 && pend_addr[1] == 32'hC) : 1'b0)
               && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_inflight_8_c", 32'(n < 50), 32'd1);
        check("t3_pre_consumed", 32'(exp_q.size()), 32'd0);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0103;
        exp_q.delete();
        push_stream(32'h100, 8);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        wait_drain("t3", 200, 1'b0);

        // redirect coinciding with the only outstanding response
        do_reset();
        lat_min = 3; lat_max = 3;
        i_imem_gnt = 1'b1;
        i_de_ready = 1'b1;
        @(posedge clk); #1;
        i_imem_gnt = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0100;
        push_stream(32'h100, 3);
        @(posedge clk); #1;
        i_redirect = 1'b0;
        i_imem_gnt = 1'b1;
        lat_min = 1; lat_max = 1;
        @(negedge clk);
        check("t4_req", 32'(o_imem_req), 32'd1);
        check("t4_addr", o_imem_addr, 32'h100);
        wait_drain("t4", 100, 1'b0);

        // random grant/latency/ready with periodic redirects (first one wraps the PC)
        do_reset();
        lat_min = 1; lat_max = 5;
        push_stream(32'h0, 64);
        for (int s = 0; s < 12; s++) begin
            n = int'($urandom_range(25, 15));
            for (int c = 0; c < n; c++) begin
                @(posedge clk); #1;
                i_redirect = 1'b0;
                i_imem_gnt = 1'($urandom_range(1, 0));
                i_de_ready = (exp_q.size() != 0) && ($urandom_range(1, 0) == 1);
            end
            @(posedge clk); #1;
            pc = (s == 0) ? 32'hFFFF_FFF9 : ($urandom & 32'h0000_FFFF);
            i_redirect    = 1'b1;
            i_redirect_pc = pc;
            i_imem_gnt    = 1'($urandom_range(1, 0));
            i_de_ready    = 1'($urandom_range(1, 0));
            exp_q.delete();
            push_stream(pc & ~32'h3, (s == 11) ? 12 : 64);
        end
        @(posedge clk); #1;
        i_redirect = 1'b0;
        wait_drain("t5", 3000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
